// File: rtl/onchip_mem_master.sv
// onchip_mem_master
//
// Avalon-MM master engine for a single-port on-chip memory (read latency 1, no waitrequest).
// It takes one FILL / CHECK / COPY command at a time and walks the memory one word per access.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_cmd_*, o_cmd_ready    command handshake (op, src, dst, len, pattern, be)
//   o_busy, o_done          progress / one-cycle completion pulse
//   o_err_count             CHECK mismatch count (saturating)
//   o_first_err_addr        address of the first CHECK mismatch
//   o_m_*, i_m_readdata     memory slave port (address, byteenable, chipselect, write, data, clken)
module onchip_mem_master #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [ADDR_W-1:0]   i_cmd_src,
    input  logic [ADDR_W-1:0]   i_cmd_dst,
    input  logic [ADDR_W:0]     i_cmd_len,
    input  logic [DATA_W-1:0]   i_cmd_pattern,
    input  logic [DATA_W/8-1:0] i_cmd_be,
    output logic                o_busy,
    output logic                o_done,
    output logic [ADDR_W:0]     o_err_count,
    output logic [ADDR_W-1:0]   o_first_err_addr,
    output logic [ADDR_W-1:0]   o_m_address,
    output logic [DATA_W/8-1:0] o_m_byteenable,
    output logic                o_m_chipselect,
    output logic                o_m_write,
    output logic [DATA_W-1:0]   o_m_writedata,
    input  logic [DATA_W-1:0]   i_m_readdata,
    output logic                o_m_clken
);

    typedef enum logic [2:0] {
        StIdle, StFill, StChkRd, StChkLast, StCpyRd, StCpyWr, StFin
    } state_e;

    localparam logic [1:0]      OP_FILL  = 2'd0;
    localparam logic [1:0]      OP_CHECK = 2'd1;
    localparam logic [1:0]      OP_COPY  = 2'd2;
    localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_src, r_dst;
    logic [ADDR_W:0]     r_len, r_i, w_i_d;
    logic [DATA_W-1:0]   r_pattern;
    logic [DATA_W/8-1:0] r_be;
    logic [ADDR_W:0]     r_err_count;
    logic [ADDR_W-1:0]   r_first_err_addr;
    // Read issued last cycle in CHK_RD; its data is compared this cycle.
    logic                r_pend;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [DATA_W-1:0]   r_pend_exp;

    logic                w_idle_like, w_accept, w_last, w_mismatch;
    logic [ADDR_W-1:0]   w_src_addr, w_dst_addr;
    logic [DATA_W-1:0]   w_fill_data;
    logic                w_cs, w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W/8-1:0] w_be;
    logic [DATA_W-1:0]   w_wd;

    // FIN also accepts, so a new command can start on the done edge.
    assign w_idle_like = (r_state == StIdle) || (r_state == StFin);
    assign w_accept    = i_cmd_valid && w_idle_like;
    assign w_last      = (r_i == r_len - LEN_ONE);
    assign w_mismatch  = r_pend && (i_m_readdata != r_pend_exp);
    // Address arithmetic wraps at the memory depth.
    assign w_src_addr  = r_src + r_i[ADDR_W-1:0];
    assign w_dst_addr  = r_dst + r_i[ADDR_W-1:0];
    assign w_fill_data = r_pattern + DATA_W'(r_i);

    always_comb begin
        w_state_d = r_state;
        w_i_d     = r_i;
        unique case (r_state)
            StIdle, StFin: begin
                w_state_d = StIdle;
                if (i_cmd_valid) begin
                    w_i_d = '0;
                    if (i_cmd_len == '0) begin
                        w_state_d = StFin;
                    end else begin
                        case (i_cmd_op)
                            OP_FILL:  w_state_d = StFill;
                            OP_CHECK: w_state_d = StChkRd;
                            OP_COPY:  w_state_d = StCpyRd;
                            default:  w_state_d = StFin;
                        endcase
                    end
                end
            end
            StFill: begin
                w_i_d = r_i + LEN_ONE;
                if (w_last) w_state_d = StFin;
            end
            StChkRd: begin
                w_i_d = r_i + LEN_ONE;
                if (w_last) w_state_d = StChkLast;
            end
            StChkLast: w_state_d = StFin;
            StCpyRd:   w_state_d = StCpyWr;
            StCpyWr: begin
                w_i_d     = r_i + LEN_ONE;
                w_state_d = w_last ? StFin : StCpyRd;
            end
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= StIdle;
            r_i              <= '0;
            r_src            <= '0;
            r_dst            <= '0;
            r_len            <= '0;
            r_pattern        <= '0;
            r_be             <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_pend           <= 1'b0;
            r_pend_addr      <= '0;
            r_pend_exp       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_i         <= w_i_d;
            r_pend      <= (r_state == StChkRd);
            r_pend_addr <= w_src_addr;
            r_pend_exp  <= w_fill_data;
            if (w_accept) begin
                r_src            <= i_cmd_src;
                r_dst            <= i_cmd_dst;
                r_len            <= i_cmd_len;
                r_pattern        <= i_cmd_pattern;
                r_be             <= i_cmd_be;
                r_err_count      <= '0;
                r_first_err_addr <= '0;
            end else if (w_mismatch) begin
                if (r_err_count == '0) r_first_err_addr <= r_pend_addr;
                if (r_err_count != '1) r_err_count <= r_err_count + LEN_ONE;
            end
        end
    end

    always_comb begin
        w_cs   = 1'b0;
        w_we   = 1'b0;
        w_addr = '0;
        w_be   = '0;
        w_wd   = '0;
        unique case (r_state)
            StFill: begin
                w_cs   = 1'b1;
                w_we   = 1'b1;
                w_addr = w_dst_addr;
                w_be   = r_be;
                w_wd   = w_fill_data;
            end
            StChkRd, StCpyRd: begin
                w_cs   = 1'b1;
                w_addr = w_src_addr;
                w_be   = '1;
            end
            StCpyWr: begin
                w_cs   = 1'b1;
                w_we   = 1'b1;
                w_addr = w_dst_addr;
                w_be   = r_be;
                // Read data from the previous cycle goes straight back out.
                w_wd   = i_m_readdata;
            end
            default: ;
        endcase
    end

    // Reset blanks the bus immediately so an interrupted command makes no further access.
    assign o_m_chipselect   = w_cs && !i_reset;
    assign o_m_write        = w_we && !i_reset;
    assign o_m_address      = i_reset ? '0 : w_addr;
    assign o_m_byteenable   = i_reset ? '0 : w_be;
    assign o_m_writedata    = i_reset ? '0 : w_wd;
    assign o_m_clken        = !i_reset;
    assign o_cmd_ready      = w_idle_like;
    assign o_busy           = !w_idle_like && !i_reset;
    assign o_done           = (r_state == StFin) && !i_reset;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_onchip_mem_master.sv
// Bench for onchip_mem_master: a latency-1 memory model on the slave side, plus a word-level
// reference of each command's effect, timing, access order and error statistics.
module tb_onchip_mem_master;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8192;
    localparam int ERR_MAX = 16383;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [12:0] cmd_src, cmd_dst;
    logic [13:0] cmd_len;
    logic [31:0] cmd_pattern;
    logic [3:0]  cmd_be;
    logic        busy, done;
    logic [13:0] err_count;
    logic [12:0] first_err_addr;
    logic [12:0] m_addr;
    logic [3:0]  m_be;
    logic        m_cs, m_write, m_clken;
    logic [31:0] m_wd, rdata;

    always #5 clk = ~clk;

    onchip_mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_src(cmd_src), .i_cmd_dst(cmd_dst), .i_cmd_len(cmd_len),
        .i_cmd_pattern(cmd_pattern), .i_cmd_be(cmd_be),
        .o_busy(busy), .o_done(done), .o_err_count(err_count),
        .o_first_err_addr(first_err_addr),
        .o_m_address(m_addr), .o_m_byteenable(m_be), .o_m_chipselect(m_cs),
        .o_m_write(m_write), .o_m_writedata(m_wd), .i_m_readdata(rdata), .o_m_clken(m_clken)
    );

    typedef struct packed {
        logic        w;
        logic [12:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } acc_t;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    acc_t        acc_q[$];
    acc_t        exp_q[$];
    logic        bd_we = 1'b0;
    logic [12:0] bd_addr = '0;
    logic [31:0] bd_data = '0;
    int          checks = 0;
    int          errors = 0;
    int          ncmd = 0;

    function automatic logic [31:0] init_val(input int a);
        return 32'(a) * 32'h9E3779B9 + 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Memory model: one process owns the array; read data appears the cycle after the read.
    initial begin : mem_model
        for (int a = 0; a < DEPTH; a++) mem[a] = init_val(a);
        forever begin
            @(posedge clk);
            if (bd_we) begin
                mem[bd_addr] = bd_data;
            end else if (m_clken && m_cs) begin
                acc_q.push_back('{w: m_write, a: m_addr, d: m_wd, be: m_be});
                if (m_write) mem[m_addr] = merge(mem[m_addr], m_wd, m_be);
                else rdata <= mem[m_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the command's effect on memory, expected access list, latency and stats.
    task automatic ref_cmd(input logic [1:0] op, input int src, input int dst, input int len,
                           input logic [31:0] pat, input logic [3:0] be,
                           output int lat, output int err, output int first);
        int sa, da;
        logic [31:0] d;
        err = 0;
        first = 0;
        exp_q.delete();
        if (len == 0 || op == 2'd3) begin
            lat = 1;
        end else if (op == 2'd0) begin
            lat = len + 1;
            for (int i = 0; i < len; i++) begin
                da = (dst + i) % DEPTH;
                d = pat + 32'(i);
                exp_q.push_back('{w: 1'b1, a: 13'(da), d: d, be: be});
                ref_mem[da] = merge(ref_mem[da], d, be);
            end
        end else if (op == 2'd1) begin
            lat = len + 2;
            for (int i = 0; i < len; i++) begin
                sa = (src + i) % DEPTH;
                exp_q.push_back('{w: 1'b0, a: 13'(sa), d: '0, be: 4'hF});
                if (ref_mem[sa] !== pat + 32'(i)) begin
                    if (err == 0) first = sa;
                    if (err != ERR_MAX) err++;
                end
            end
        end else begin
            lat = 2 * len + 1;
            for (int i = 0; i < len; i++) begin
                sa = (src + i) % DEPTH;
                da = (dst + i) % DEPTH;
                d = ref_mem[sa];
                exp_q.push_back('{w: 1'b0, a: 13'(sa), d: '0, be: 4'hF});
                exp_q.push_back('{w: 1'b1, a: 13'(da), d: d, be: be});
                ref_mem[da] = merge(ref_mem[da], d, be);
            end
        end
    endtask

    function automatic string tg(input string s);
        return $sformatf("%s[cmd%0d]", s, ncmd);
    endfunction

    task automatic mem_cmp(input string s);
        int bad;
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) bad++;
        chk(tg(s), 64'(bad), 64'd0);
    endtask

    // Called mid-cycle; returns mid-cycle in the done cycle (back-to-back capable).
    task automatic run_cmd(input logic [1:0] op, input int src, input int dst, input int len,
                           input logic [31:0] pat, input logic [3:0] be, input bit garbage,
                           output int obs_lat);
        int lat, err, first, n, busy_bad, seq_bad;
        bit got;
        ref_cmd(op, src, dst, len, pat, be, lat, err, first);
        ncmd++;
        chk(tg("ready"), 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_src = 13'(src);
        cmd_dst = 13'(dst);
        cmd_len = 14'(len);
        cmd_pattern = pat;
        cmd_be = be;
        acc_q.delete();
        @(posedge clk);
        #1;
        n = 0;
        got = 1'b0;
        busy_bad = 0;
        while (!got && n < lat + 10) begin
            n++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (!busy) busy_bad++;
                // Offers while busy must be ignored.
                if (garbage && n < lat) begin
                    cmd_valid = 1'b1;
                    cmd_op = 2'($urandom);
                    cmd_src = 13'($urandom);
                    cmd_dst = 13'($urandom);
                    cmd_len = 14'($urandom_range(1, 20));
                    cmd_pattern = $urandom;
                    cmd_be = 4'($urandom);
                end else begin
                    cmd_valid = 1'b0;
                end
                @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
        obs_lat = n;
        chk(tg("done_lat"), 64'(n), 64'(lat));
        chk(tg("busy_run"), 64'(busy_bad), 64'd0);
        chk(tg("busy_fin"), 64'(busy), 64'd0);
        chk(tg("err_count"), 64'(err_count), 64'(err));
        chk(tg("first_err"), 64'(first_err_addr), 64'(first));
        seq_bad = (acc_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            if (acc_q[i].w !== exp_q[i].w || acc_q[i].a !== exp_q[i].a) seq_bad++;
            else if (exp_q[i].w && (acc_q[i].d !== exp_q[i].d || acc_q[i].be !== exp_q[i].be))
                seq_bad++;
        end
        chk(tg("acc_seq"), 64'(seq_bad), 64'd0);
        mem_cmp("mem");
    endtask

    task automatic bd_write(input int a, input logic [31:0] d);
        bd_we = 1'b1;
        bd_addr = 13'(a);
        bd_data = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk(tg("idle"), 64'({done, busy, cmd_ready, m_cs}), 64'(4'b0010));
        end
    endtask

    initial begin : main
        int lat, len, src, dst;
        logic [1:0]  op;
        logic [31:0] pat;
        logic [3:0]  be;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_val(a);
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_src = '0;
        cmd_dst = '0;
        cmd_len = '0;
        cmd_pattern = '0;
        cmd_be = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc_clken", 64'(m_clken), 64'd0);
        chk("rst_cyc_cs", 64'(m_cs), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_stats", 64'({err_count, first_err_addr}), 64'd0);
        chk("rst_bus", 64'({m_cs, m_write, m_addr, m_be}), 64'd0);
        chk("rst_wd", 64'(m_wd), 64'd0);
        chk("rst_clken", 64'(m_clken), 64'd1);

        // FILL then CHECK clean, then CHECK with one corrupted word.
        run_cmd(2'd0, 0, 'h10, 4, 32'hA0000000, 4'hF, 1'b0, lat);
        chk("tp_fill_lat", 64'(lat), 64'd5);
        chk("tp_fill_w3", 64'(mem['h13]), 64'h A0000003);
        idle(1);
        run_cmd(2'd1, 'h10, 0, 4, 32'hA0000000, 4'hF, 1'b0, lat);
        chk("tp_chk_lat", 64'(lat), 64'd6);
        chk("tp_chk_err0", 64'(err_count), 64'd0);
        bd_write('h12, 32'h0);
        run_cmd(2'd1, 'h10, 0, 4, 32'hA0000000, 4'hF, 1'b0, lat);
        chk("tp_chk_err1", 64'(err_count), 64'd1);
        chk("tp_chk_first", 64'(first_err_addr), 64'h12);

        // COPY across the top-of-memory wrap.
        run_cmd(2'd2, 'h1FFE, 'h100, 4, 32'h0, 4'hF, 1'b0, lat);
        chk("tp_copy_lat", 64'(lat), 64'd9);
        chk("tp_copy_w2", 64'(mem['h102]), 64'(init_val(0)));

        // Partial byteenable over all-ones words.
        for (int a = 'h300; a < 'h304; a++) bd_write(a, 32'hFFFFFFFF);
        run_cmd(2'd0, 0, 'h300, 4, 32'h12345678, 4'h3, 1'b0, lat);
        chk("tp_be_w1", 64'(mem['h301]), 64'hFFFF5679);
        chk("tp_be_w3", 64'(mem['h303]), 64'hFFFF567B);

        // Zero-length, then back-to-back on the done cycle; reserved op.
        run_cmd(2'd0, 0, 'h400, 0, 32'h1, 4'hF, 1'b0, lat);
        chk("tp_len0_lat", 64'(lat), 64'd1);
        run_cmd(2'd1, 'h10, 0, 2, 32'hA0000000, 4'hF, 1'b0, lat);
        run_cmd(2'd3, 'h10, 'h20, 5, 32'h1, 4'hF, 1'b0, lat);
        chk("tp_op3_lat", 64'(lat), 64'd1);
        idle(2);

        // Reset during an 8-word FILL: reset high in cycle k+3.
        ncmd++;
        acc_q.delete();
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        cmd_dst = 13'h40;
        cmd_len = 14'd8;
        cmd_pattern = 32'h55550000;
        cmd_be = 4'hF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk(tg("mid_rst_cs"), 64'(m_cs), 64'd0);
        chk(tg("mid_rst_ready"), 64'(cmd_ready), 64'd1);
        chk(tg("mid_rst_done"), 64'(done), 64'd0);
        idle(4);
        chk(tg("mid_rst_nacc"), 64'(acc_q.size()), 64'd2);
        ref_mem['h40] = 32'h55550000;
        ref_mem['h41] = 32'h55550001;
        mem_cmp("mid_rst_mem");

        // Long CHECK revisiting addresses past the memory depth.
        run_cmd(2'd1, 'h1F00, 0, DEPTH + 1, 32'h0BADF00D, 4'hF, 1'b0, lat);
        idle(1);

        // Randomized commands against the reference.
        for (int it = 0; it < 40; it++) begin
            op = 2'($urandom_range(0, 3));
            len = $urandom_range(0, 12);
            src = $urandom_range(0, DEPTH - 1);
            dst = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 2) == 0) src = DEPTH - 4 + $urandom_range(0, 3);
            pat = $urandom;
            be = 4'($urandom);
            if (op == 2'd2 && $urandom_range(0, 1) == 1) dst = (src + $urandom_range(1, 3)) % DEPTH;
            if (op == 2'd1 && len > 0 && $urandom_range(0, 1) == 1) begin
                run_cmd(2'd0, 0, src, len, pat, 4'hF, 1'b1, lat);
                if ($urandom_range(0, 1) == 1)
                    bd_write((src + $urandom_range(0, len - 1)) % DEPTH, $urandom);
            end
            run_cmd(op, src, dst, len, pat, be, 1'b1, lat);
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
